// File: rtl/pkt_buf_pkg.sv
// Shared defaults and ring-pointer helper for the packet SRAM buffer.
package pkt_buf_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 3072;
    localparam int DEF_PKT_CW = 8;

    // Wraps at depth-1 so the ring depth need not be a power of two.
    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input int unsigned depth);
        return (ptr == 32'(depth - 1)) ? 32'd0 : ptr + 32'd1;
    endfunction
endpackage

// File: rtl/pkt_sram_buf_sdp_sram.sv
// Simple dual-port RAM: one write port, one read port with a registered output.
module sdp_sram #(
    parameter int WIDTH  = 9,
    parameter int DEPTH  = 3072,
    parameter int ADDR_W = 12
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge i_clk) begin
        if (i_we) mem[i_waddr] <= i_wdata;
        if (i_re) rdata_q <= mem[i_raddr];
    end

    assign o_rdata = rdata_q;
endmodule

// File: rtl/pkt_sram_buf.sv
// Packet buffer over a dual-port SRAM: packets become readable only once committed.
// Define PKT_SRAM_BUF_RD_REG_EN to add a register after the RAM (latency +1, 3-entry skid).
module pkt_sram_buf
    import pkt_buf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int PKT_CW = DEF_PKT_CW
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_valid,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_wr_last,
    input  logic              i_wr_drop,
    output logic              o_wr_ready,
    output logic              o_rd_valid,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_last,
    input  logic              i_rd_ready,
    output logic [PKT_CW-1:0] o_pkt_cnt,
    output logic              o_drop
);
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
`ifdef PKT_SRAM_BUF_RD_REG_EN
    localparam int SKID = 3;
`else
    localparam int SKID = 2;
`endif
    localparam int SK_W = $clog2(SKID);
    localparam int SC_W = 2;
    localparam logic [PKT_CW-1:0] PKT_MAX = {PKT_CW{1'b1}};

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } ram_word_t;

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, cm_ptr_q, cm_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_inc, rd_ptr_inc;
    logic [CNT_W-1:0]  unc_q, unc_d, avail_q, avail_d;
    logic              err_q, err_d, drop_q, wr_ready_q, wr_ready_d, rvld1_q;
    logic [PKT_CW-1:0] pkt_cnt_q, pkt_cnt_d;
    logic              wr_acc, discard, commit, issue, pop, push, last_pop;
    logic [1:0]        inflight;
    ram_word_t         ram_rdata, push_word;
    ram_word_t         skid_q [SKID];
    logic [SK_W-1:0]   sk_head_q, sk_head_d, sk_tail_q, sk_tail_d;
    logic [SC_W-1:0]   sk_cnt_q, sk_cnt_d;

    sdp_sram #(.WIDTH(DATA_W + 1), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
        .i_clk   (i_clk),
        .i_we    (wr_acc),
        .i_waddr (wr_ptr_q),
        .i_wdata ({i_wr_last, i_wr_data}),
        .i_re    (issue),
        .i_raddr (rd_ptr_q),
        .o_rdata (ram_rdata)
    );

`ifdef PKT_SRAM_BUF_RD_REG_EN
    logic      rvld2_q;
    ram_word_t rdata2_q;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rvld2_q  <= 1'b0;
            rdata2_q <= '0;
        end else begin
            rvld2_q  <= rvld1_q;
            rdata2_q <= ram_rdata;
        end
    end
    assign push      = rvld2_q;
    assign push_word = rdata2_q;
    assign inflight  = {1'b0, rvld1_q} + {1'b0, rvld2_q};
`else
    assign push      = rvld1_q;
    assign push_word = ram_rdata;
    assign inflight  = {1'b0, rvld1_q};
`endif

    assign o_rd_valid = (sk_cnt_q != '0);
    assign o_rd_data  = skid_q[sk_head_q].data;
    assign o_rd_last  = skid_q[sk_head_q].last;
    assign o_wr_ready = wr_ready_q;
    assign o_pkt_cnt  = pkt_cnt_q;
    assign o_drop     = drop_q;

    always_comb begin
        wr_acc     = i_wr_valid && wr_ready_q;
        // A word refused for lack of space poisons its packet; the last word then rewinds it.
        discard    = i_wr_drop || (i_wr_valid && i_wr_last && (err_q || !wr_ready_q));
        commit     = wr_acc && i_wr_last && !err_q && !i_wr_drop;
        pop        = o_rd_valid && i_rd_ready;
        last_pop   = pop && o_rd_last;
        wr_ptr_inc = ADDR_W'(ptr_inc(32'(wr_ptr_q), DEPTH));
        rd_ptr_inc = ADDR_W'(ptr_inc(32'(rd_ptr_q), DEPTH));
        // Prefetch only when the skid can absorb everything already in flight.
        issue      = (avail_q != '0) &&
                     ((int'(sk_cnt_q) + int'(inflight) - int'(pop)) < SKID);

        wr_ptr_d = wr_ptr_q;
        cm_ptr_d = cm_ptr_q;
        unc_d    = unc_q;
        err_d    = err_q;
        if (discard) begin
            wr_ptr_d = cm_ptr_q;
            unc_d    = '0;
            err_d    = 1'b0;
        end else if (commit) begin
            wr_ptr_d = wr_ptr_inc;
            cm_ptr_d = wr_ptr_inc;
            unc_d    = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_inc;
                unc_d    = unc_q + CNT_W'(1);
            end
            if (i_wr_valid && !wr_ready_q) err_d = 1'b1;
        end

        avail_d    = avail_q + (commit ? unc_q + CNT_W'(1) : '0) - (issue ? CNT_W'(1) : '0);
        rd_ptr_d   = issue ? rd_ptr_inc : rd_ptr_q;
        wr_ready_d = ((unc_d + avail_d) != CNT_W'(DEPTH));

        pkt_cnt_d = pkt_cnt_q;
        if (commit && !last_pop && pkt_cnt_q != PKT_MAX) pkt_cnt_d = pkt_cnt_q + 1'b1;
        else if (!commit && last_pop && pkt_cnt_q != '0) pkt_cnt_d = pkt_cnt_q - 1'b1;

        sk_tail_d = sk_tail_q;
        sk_head_d = sk_head_q;
        if (push) sk_tail_d = (sk_tail_q == SK_W'(SKID - 1)) ? '0 : sk_tail_q + SK_W'(1);
        if (pop)  sk_head_d = (sk_head_q == SK_W'(SKID - 1)) ? '0 : sk_head_q + SK_W'(1);
        sk_cnt_d = sk_cnt_q + SC_W'(push) - SC_W'(pop);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q   <= '0;
            cm_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            unc_q      <= '0;
            avail_q    <= '0;
            err_q      <= 1'b0;
            drop_q     <= 1'b0;
            wr_ready_q <= 1'b1;
            rvld1_q    <= 1'b0;
            pkt_cnt_q  <= '0;
            sk_head_q  <= '0;
            sk_tail_q  <= '0;
            sk_cnt_q   <= '0;
            for (int i = 0; i < SKID; i++) skid_q[i] <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            cm_ptr_q   <= cm_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            unc_q      <= unc_d;
            avail_q    <= avail_d;
            err_q      <= err_d;
            drop_q     <= discard;
            wr_ready_q <= wr_ready_d;
            rvld1_q    <= issue;
            pkt_cnt_q  <= pkt_cnt_d;
            sk_head_q  <= sk_head_d;
            sk_tail_q  <= sk_tail_d;
            sk_cnt_q   <= sk_cnt_d;
            if (push) skid_q[sk_tail_q] <= push_word;
        end
    end
endmodule
